// File: rtl/float_to_int_pkg.sv
// Shared definitions for the float-to-int converter: state encoding, IEEE-754
// single-precision field positions and the saturation constant.
package float_to_int_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    GET_A         = 3'd0,
    UNPACK        = 3'd1,
    SPECIAL_CASES = 3'd2,
    CONVERT       = 3'd3,
    PACK          = 3'd4,
    PUT_Z         = 3'd5
  } state_e;

  localparam int EXP_BIAS = 127;
  localparam logic [DATA_W-1:0] INT_MIN = 32'h8000_0000;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;

endpackage

// File: rtl/float_to_int_if.sv
// Operand/result handshake bundle for float_to_int: stb/ack pairs on each side.
interface float_to_int_if;
  import float_to_int_pkg::*;

  logic [DATA_W-1:0] input_a;
  logic              input_a_stb;
  logic              input_a_ack;
  logic [DATA_W-1:0] output_z;
  logic              output_z_stb;
  logic              output_z_ack;

  modport master (
    output input_a, input_a_stb, output_z_ack,
    input  input_a_ack, output_z, output_z_stb
  );

  modport slave (
    input  input_a, input_a_stb, output_z_ack,
    output input_a_ack, output_z, output_z_stb
  );

endinterface

// File: rtl/float_to_int.sv
// Serial IEEE-754 single to signed 32-bit integer converter; truncates toward
// zero, saturates out-of-range, inf and NaN to INT_MIN. One operand in flight.
module float_to_int
  import float_to_int_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  float_to_int_if.slave io
);

  state_e                    state_q, state_d;
  logic                      ack_q, ack_d;
  logic                      stb_q, stb_d;
  logic        [DATA_W-1:0]  out_q, out_d;
  logic        [DATA_W-1:0]  a_q, a_d;
  logic                      a_s_q, a_s_d;
  logic signed [9:0]         a_e_q, a_e_d;
  logic        [DATA_W-1:0]  a_m_q, a_m_d;
  logic        [DATA_W-1:0]  z_q, z_d;

  function automatic logic [DATA_W-1:0] apply_sign(input logic neg,
                                                   input logic [DATA_W-1:0] mag);
    return neg ? -mag : mag;
  endfunction

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    stb_d   = stb_q;
    out_d   = out_q;
    a_d     = a_q;
    a_s_d   = a_s_q;
    a_e_d   = a_e_q;
    a_m_d   = a_m_q;
    z_d     = z_q;
    case (state_q)
      GET_A: begin
        ack_d = 1'b1;
        if (ack_q && io.input_a_stb) begin
          a_d     = io.input_a;
          ack_d   = 1'b0;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        a_s_d   = a_q[SIGN_BIT];
        a_e_d   = $signed({2'b00, a_q[EXP_MSB:EXP_LSB]}) - $signed(10'(EXP_BIAS));
        a_m_d   = {1'b1, a_q[MAN_MSB:0], 8'b0};
        state_d = SPECIAL_CASES;
      end
      SPECIAL_CASES: begin
        // Below 1.0 truncates to zero; 2^31 and beyond (incl. inf/NaN) saturates.
        if (a_e_q < 10'sd0) begin
          z_d     = '0;
          state_d = PUT_Z;
        end else if (a_e_q > 10'sd30) begin
          z_d     = INT_MIN;
          state_d = PUT_Z;
        end else begin
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (a_e_q < 10'sd31) begin
          a_m_d = a_m_q >> 1;
          a_e_d = a_e_q + 10'sd1;
        end else begin
          state_d = PACK;
        end
      end
      PACK: begin
        z_d     = apply_sign(a_s_q, a_m_q);
        state_d = PUT_Z;
      end
      PUT_Z: begin
        stb_d = 1'b1;
        out_d = z_q;
        if (stb_q && io.output_z_ack) begin
          stb_d   = 1'b0;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GET_A;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
      out_q   <= out_d;
    end
  end

  // Working registers carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    a_s_q <= a_s_d;
    a_e_q <= a_e_d;
    a_m_q <= a_m_d;
    z_q   <= z_d;
  end

  assign io.input_a_ack  = ack_q;
  assign io.output_z_stb = stb_q;
  assign io.output_z     = out_q;

endmodule

// File: tb/tb_float_to_int.sv
// Directed and randomized bench for float_to_int against an arithmetic
// reference of float-to-int truncation and cycle latency.
module tb_float_to_int;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;

  float_to_int_if bus();

  float_to_int dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_val(input logic [31:0] f);
    int     e;
    longint mag;
    logic [63:0] r;
    e = int'(f[30:23]) - 127;
    if (e < 0)  return 32'h0000_0000;
    if (e > 30) return 32'h8000_0000;
    mag = longint'({1'b1, f[22:0]});
    if (e >= 23) mag = mag * (longint'(1) << (e - 23));
    else         mag = mag / (longint'(1) << (23 - e));
    if (f[31]) mag = -mag;
    r = 64'(mag);
    return r[31:0];
  endfunction

  function automatic int ref_lat(input logic [31:0] f);
    int e;
    e = int'(f[30:23]) - 127;
    if (e < 0 || e > 30) return 3;
    return 36 - e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one operand, check latency/value, optionally stall the result.
  task automatic do_op(input logic [31:0] f, input int hold);
    int k;
    logic [31:0] held;
    bus.input_a     = f;
    bus.input_a_stb = 1'b1;
    k = 0;
    while (!bus.input_a_ack && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("accept_timeout", 32'(bus.input_a_ack), 32'd1);
    @(posedge clk); #1;
    bus.input_a_stb = 1'b0;
    bus.input_a     = $urandom;
    check("ack_drop", 32'(bus.input_a_ack), 32'd0);
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (bus.output_z_stb) begin
        k = i;
        break;
      end
      if (bus.input_a_ack) break;
    end
    check($sformatf("latency_%h", f), 32'(k), 32'(ref_lat(f)));
    check($sformatf("value_%h", f), bus.output_z, ref_val(f));
    held = bus.output_z;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_stb", 32'(bus.output_z_stb), 32'd1);
      check("hold_z", bus.output_z, held);
      check("hold_in_ack", 32'(bus.input_a_ack), 32'd0);
    end
    bus.output_z_ack = 1'b1;
    @(posedge clk); #1;
    bus.output_z_ack = 1'b0;
    check("stb_drop", 32'(bus.output_z_stb), 32'd0);
  endtask

  initial begin
    int k;
    int stray;
    logic [31:0] f;

    bus.input_a      = '0;
    bus.input_a_stb  = 1'b0;
    bus.output_z_ack = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ack", 32'(bus.input_a_ack), 32'd0);
    check("rst_out_stb", 32'(bus.output_z_stb), 32'd0);
    check("rst_out_z", bus.output_z, 32'd0);
    rst = 1'b0;
    k = 0;
    while (!bus.input_a_ack && k < 4) begin
      @(posedge clk); #1;
      k++;
    end
    check("ack_after_rst", 32'(bus.input_a_ack), 32'd1);

    // Directed values
    do_op(32'h3F80_0000, 0);
    do_op(32'hC2F6_E979, 0);
    check("neg123_model", ref_val(32'hC2F6_E979), 32'hFFFF_FF85);
    do_op(32'h4EFF_FFFF, 0);
    do_op(32'h3F00_0000, 0);
    do_op(32'h8000_0000, 0);
    do_op(32'h0000_0001, 0);
    do_op(32'h7F80_0000, 0);
    do_op(32'h7FC0_0000, 0);
    do_op(32'h4F00_0000, 0);
    do_op(32'hCF00_0000, 0);
    do_op(32'h4E80_0001, 0);
    do_op(32'hBF80_0000, 0);

    // Backpressure, then a follow-up conversion
    do_op(32'h4640_E400, 10);
    do_op(32'hC479_8000, 0);

    // Reset during convert abandons the operand
    bus.input_a     = 32'h3F80_0000;
    bus.input_a_stb = 1'b1;
    k = 0;
    while (!bus.input_a_ack && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    bus.input_a_stb = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ack", 32'(bus.input_a_ack), 32'd0);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.output_z_stb) stray++;
    end
    check("midrst_no_output", 32'(stray), 32'd0);
    do_op(32'h4040_0000, 0);
    check("three_model", ref_val(32'h4040_0000), 32'h0000_0003);

    // Randomized operands, mostly in the convertible exponent range
    for (int n = 0; n < 60; n++) begin
      f = $urandom;
      if (n % 3 != 0) f[30:23] = 8'($urandom_range(120, 162));
      do_op(f, (n % 7 == 0) ? $urandom_range(1, 4) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
